// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control sequencer with bus-timeout and reserved-instruction traps.
// Define MC_CTRL_COP0_EN to decode MFC0/MTC0; otherwise op 0x10 is treated as reserved.
module mc_controller #(
  parameter int MEM_TIMEOUT   = 15,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic        memReady,
  input  logic        branchTaken,
  output logic [2:0]  state,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        irWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic [1:0]  writeRegSrc,
  output logic        aluStart,
  output logic        cp0Write,
  output logic        exception,
  output logic [4:0]  excCode,
  output logic        instRetire
);
  // state       | meaning
  // FETCH       | read instruction word, wait for memReady (bounded)
  // DECODE      | classify IR, trap on reserved opcode
  // EXEC        | branch/jump/MTC0 complete here, others dispatch
  // MEM         | load/store handshake (bounded)
  // WB          | register-file write
  // MULDIV_WAIT | iterative mul/div in progress
  // TRAP        | one-cycle exception pulse
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_MULDIV = 3'd5, S_TRAP = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_MULDIV, C_J, C_JAL, C_JR, C_JALR, C_BRANCH,
    C_IALU, C_LOAD, C_STORE, C_MFC0, C_MTC0, C_RSVD
  } class_t;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam int MW = $clog2(MULDIV_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [MW-1:0] MD_LOAD  = MW'(MULDIV_CYCLES);

  state_t        stateQ, stateD;
  class_t        cls;
  logic [TW-1:0] tmoCnt;
  logic [MW-1:0] mdCnt;
  logic [4:0]    excQ, excD;
  logic          rstHold, live;
  logic [5:0]    op, func;
  logic          unusedIns;

  assign op        = ins[31:26];
  assign func      = ins[5:0];
  assign unusedIns = ^ins[25:6];
  // rstHold keeps the first cycle after reset strobe-free so no stale request restarts.
  assign live      = !rst && !rstHold;

  always_comb begin
    cls = C_RSVD;
    case (op)
      6'h00: begin
        case (func)
          6'h08: cls = C_JR;
          6'h09: cls = C_JALR;
          6'h18, 6'h19, 6'h1a, 6'h1b: cls = C_MULDIV;
          default: cls = C_RALU;
        endcase
      end
      6'h02: cls = C_J;
      6'h03: cls = C_JAL;
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: cls = C_BRANCH;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: cls = C_IALU;
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: cls = C_LOAD;
      6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e: cls = C_STORE;
`ifdef MC_CTRL_COP0_EN
      6'h10: begin
        if (ins[10:3] == 8'h00) begin
          if (ins[25:21] == 5'd0) cls = C_MFC0;
          else if (ins[25:21] == 5'd4) cls = C_MTC0;
        end
      end
`endif
      default: cls = C_RSVD;
    endcase
  end

  always_comb begin
    stateD      = stateQ;
    excD        = excQ;
    pcWrite     = 1'b0;
    pcSrc       = 2'd0;
    irWrite     = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    regWrite    = 1'b0;
    writeRegSrc = 2'd0;
    aluStart    = 1'b0;
    cp0Write    = 1'b0;
    if (live) begin
      case (stateQ)
        S_FETCH: begin
          memRead = 1'b1;
          if (memReady) begin
            irWrite = 1'b1;
            pcWrite = 1'b1;
            stateD  = S_DECODE;
          end else if (tmoCnt == TMO_LAST) begin
            stateD = S_TRAP;
            excD   = 5'd6;
          end
        end
        S_DECODE: begin
          if (cls == C_RSVD) begin
            stateD = S_TRAP;
            excD   = 5'd10;
          end else begin
            stateD = S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls)
            C_BRANCH: begin
              pcWrite = branchTaken;
              pcSrc   = 2'd1;
              stateD  = S_FETCH;
            end
            C_J, C_JAL, C_JR, C_JALR: begin
              pcWrite = 1'b1;
              pcSrc   = (cls == C_J || cls == C_JAL) ? 2'd2 : 2'd3;
              if (cls == C_JAL || cls == C_JALR) begin
                regWrite    = 1'b1;
                writeRegSrc = 2'd3;
              end
              stateD = S_FETCH;
            end
            C_MULDIV: begin
              aluStart = 1'b1;
              stateD   = S_MULDIV;
            end
            C_LOAD, C_STORE: stateD = S_MEM;
`ifdef MC_CTRL_COP0_EN
            C_MTC0: begin
              cp0Write = 1'b1;
              stateD   = S_FETCH;
            end
`endif
            default: stateD = S_WB;
          endcase
        end
        S_MEM: begin
          memRead  = (cls == C_LOAD);
          memWrite = (cls == C_STORE);
          if (memReady) begin
            stateD = (cls == C_LOAD) ? S_WB : S_FETCH;
          end else if (tmoCnt == TMO_LAST) begin
            stateD = S_TRAP;
            excD   = 5'd7;
          end
        end
        S_WB: begin
          regWrite = 1'b1;
          case (cls)
            C_LOAD: writeRegSrc = 2'd1;
`ifdef MC_CTRL_COP0_EN
            C_MFC0: writeRegSrc = 2'd2;
`endif
            default: writeRegSrc = 2'd0;
          endcase
          stateD = S_FETCH;
        end
        S_MULDIV: begin
          if (mdCnt <= MW'(1)) stateD = S_FETCH;
        end
        default: stateD = S_FETCH;
      endcase
    end else begin
      stateD = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= S_FETCH;
      tmoCnt  <= '0;
      mdCnt   <= '0;
      excQ    <= '0;
      rstHold <= 1'b1;
    end else begin
      rstHold <= 1'b0;
      stateQ  <= stateD;
      excQ    <= excD;
      if (stateD != stateQ) tmoCnt <= '0;
      else if (live && (stateQ == S_FETCH || stateQ == S_MEM)) tmoCnt <= tmoCnt + TW'(1);
      if (aluStart) mdCnt <= MD_LOAD;
      else if (stateQ == S_MULDIV && mdCnt != '0) mdCnt <= mdCnt - MW'(1);
    end
  end

  assign state      = stateQ;
  assign excCode    = excQ;
  assign exception  = live && (stateQ == S_TRAP);
  assign instRetire = live && (stateD == S_FETCH) && (stateQ != S_FETCH) && (stateQ != S_TRAP);

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS instruction decoder.
- Decodes the 32-bit instruction held in the external IR and sequences one instruction over several cycles: FETCH, DECODE, EXEC, then MEM and/or WB where needed.
- Emits per-cycle datapath strobes.
- Parametrised memory wait/timeout and iterative mul/div latency; adds bus-timeout and reserved-instruction exceptions.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory request waits for memReady before a bus-error exception (>=1)
MULDIV_CYCLES, 32, cycles spent in MULDIV_WAIT after aluStart (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
ins  input  32  instruction from external IR (valid from DECODE until the next FETCH completes)
memReady  input  1  memory handshake: request completes in the cycle this is high
branchTaken  input  1  ALU compare result for current branch, sampled in EXEC
state  output  3  current state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 MULDIV_WAIT=5 TRAP=6
pcWrite  output  1  load PC this cycle
pcSrc  output  2  0=PC+4, 1=branch target, 2=jump target, 3=rs
irWrite  output  1  latch fetched word into IR
memRead  output  1  memory read request (held until memReady)
memWrite  output  1  memory write request (held until memReady)
regWrite  output  1  register-file write strobe
writeRegSrc  output  2  0=ALU, 1=memory, 2=CP0, 3=link (PC+4)
aluStart  output  1  one-cycle start pulse for iterative mul/div
cp0Write  output  1  MTC0 write strobe
exception  output  1  one-cycle exception pulse
excCode  output  5  6=fetch bus error, 7=data bus error, 10=reserved instruction; held until the next exception
instRetire  output  1  one-cycle pulse when an instruction completes without exception

Behaviour:
- Reset: state=FETCH; timeout and mul/div counters=0. All outputs 0, including excCode.
- Reset mid-operation: any pending memory request is abandoned. memRead and memWrite are 0 in the cycle after rst is sampled high.
- Decode classes, using the standard MIPS op field [31:26] and func field [5:0]:
  - R-ALU: op 0, except func JR/JALR/MULT/MULTU/DIV/DIVU.
  - MULDIV: op 0, func 0x18-0x1b.
  - JUMP: J 0x02, JAL 0x03, JR func 0x08, JALR func 0x09.
  - BRANCH: 0x01, 0x04-0x07.
  - I-ALU: 0x08-0x0f.
  - LOAD: 0x20-0x26.
  - STORE: 0x28, 0x29, 0x2a, 0x2b, 0x2e.
  - COP0: 0x10 with ins[10:3]=0; rs=0 is MFC0, rs=4 is MTC0.
  - Anything else is reserved.
- FETCH:
  - memRead=1 until memReady.
  - On memReady: irWrite=1, pcWrite=1, pcSrc=0, go to DECODE.
  - Timeout counter increments each waiting cycle. Reaching MEM_TIMEOUT without memReady goes to TRAP with excCode=6.
  - memReady in the same cycle as the limit counts as success.
- DECODE: one cycle, no strobes. Reserved instruction goes to TRAP with excCode=10; otherwise go to EXEC.
- EXEC, one cycle, by class:
  - BRANCH: pcWrite=branchTaken, pcSrc=1; go to FETCH.
  - JUMP: pcWrite=1; pcSrc=2 for J/JAL, 3 for JR/JALR. JAL/JALR also assert regWrite=1 with writeRegSrc=3. Go to FETCH.
  - MULDIV: aluStart=1; go to MULDIV_WAIT.
  - R-ALU, I-ALU, MFC0: go to WB.
  - MTC0: cp0Write=1; go to FETCH.
  - LOAD/STORE: go to MEM.
- MULDIV_WAIT: counts MULDIV_CYCLES cycles (counter width $clog2(MULDIV_CYCLES+1)), then goes to FETCH.
- MEM:
  - memRead (load) or memWrite (store) held high until memReady.
  - Load then goes to WB; store goes to FETCH.
  - Timeout behaves as in FETCH, but TRAP uses excCode=7.
  - The timeout counter clears on every state entry.
- WB: regWrite=1 for one cycle. writeRegSrc is 0 for ALU classes, 1 for LOAD, 2 for MFC0. Go to FETCH.
- TRAP: exception=1 for one cycle, no other strobes; go to FETCH. PC redirect is handled by CP0.
- instRetire=1 on every transition into FETCH except from TRAP.
- Outputs are a pure function of state, ins, memReady, branchTaken and counters (Moore plus the handshake terms above).
- writeRegSrc is 0 whenever regWrite=0.

Optional Feature:
- Macro: MC_CTRL_COP0_EN.
- When defined: MFC0/MTC0 decode and sequence as above.
- When undefined: op 0x10 is reserved (TRAP, excCode=10); cp0Write is tied to 0; writeRegSrc never takes the value 2.

Test Plan:
- Reset then ADDU 0x00221821 with memReady high every request -> states 0,1,2,4,0. regWrite=1 with writeRegSrc=0 in WB; instRetire pulses once; 4 cycles per instruction.
- LW 0x8c220004 with memReady delayed 3 cycles in MEM -> memRead high for 4 MEM cycles; WB regWrite=1, writeRegSrc=1.
- BEQ with branchTaken=1 -> EXEC pcWrite=1, pcSrc=1. With branchTaken=0 -> pcWrite=0. Both return to FETCH after 3 cycles.
- MULT 0x00430018, MULDIV_CYCLES=32 -> aluStart pulse in EXEC, 32 cycles in state 5, then FETCH; no regWrite.
- FETCH with memReady never high, MEM_TIMEOUT=15 -> TRAP after 15 cycles; exception pulse, excCode=6, no instRetire. Opcode 0x3f -> TRAP, excCode=10.
- JAL 0x0c000010 -> EXEC pcWrite=1, pcSrc=2, regWrite=1, writeRegSrc=3. rst asserted mid-MEM -> memRead/memWrite 0 next cycle, state=0.
